// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader: FSM state encoding,
// frame sync byte and the width of the little-endian length field.
package program_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CHECK,
        DONE,
        ERROR
    } loader_state_e;

    localparam logic [7:0] LOADER_SYNC_BYTE = 8'hA5;
    localparam int         LOADER_LEN_BYTES = 4;

endpackage

// File: rtl/program_loader_if.sv
// Byte stream in from the UART receiver and program-memory write port out.
// rx_valid is a one-cycle strobe with no back-pressure; write_enable is a one-cycle strobe.
interface program_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [31:0] write_address;
    logic [7:0]  write_data;
    logic        write_enable;

    modport master (
        input  rx_data,
        input  rx_valid,
        output write_address,
        output write_data,
        output write_enable
    );

    modport slave (
        output rx_data,
        output rx_valid,
        input  write_address,
        input  write_data,
        input  write_enable
    );
endinterface

// File: rtl/loader_timeout.sv
// Idle-cycle counter: counts enabled cycles without clear, expired is a
// registered level that rises once LIMIT idle cycles have elapsed.
module loader_timeout #(
    parameter int LIMIT = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int             CW      = $clog2(LIMIT + 1);
    localparam logic [CW-1:0]  LIMIT_C = CW'(LIMIT);

    logic [CW-1:0] count_q;

    // Saturates at LIMIT so a long silence cannot wrap back to "not expired".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            expired <= 1'b0;
        end else if (clear || !enable) begin
            count_q <= '0;
            expired <= 1'b0;
        end else if (count_q != LIMIT_C) begin
            count_q <= count_q + CW'(1);
            expired <= ((count_q + CW'(1)) == LIMIT_C);
        end
    end

endmodule

// File: rtl/program_loader.sv
// Frames a UART byte stream (sync, 4-byte length, payload[, checksum]) into
// program-memory writes and releases the CPU reset after a clean load. Option: LOADER_CHECKSUM_EN.
module program_loader
    import program_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          MAX_BYTES      = 4096,
    parameter int          TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    program_loader_if.master        bus,
    output logic                    cpu_reset_n,
    output logic                    load_done,
    output logic                    load_error,
    output loader_state_e           state_dbg
);

    loader_state_e state_q, state_d;
    logic [31:0]   len_q;
    logic [31:0]   len_full;
    logic [1:0]    len_cnt_q;
    logic [31:0]   idx_q;
    logic          wr_en_q;
    logic [31:0]   wr_addr_q;
    logic [7:0]    wr_data_q;
    logic          to_enable;
    logic          to_expired;
    logic          is_sync;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    sum_q;
`endif

    // Length bytes arrive LSB first, so each new byte enters at the top.
    assign len_full  = {bus.rx_data, len_q[31:8]};
    assign is_sync   = bus.rx_valid && (bus.rx_data == LOADER_SYNC_BYTE);
    assign to_enable = (state_q == LEN) || (state_q == DATA) || (state_q == CHECK);

    loader_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .enable  (to_enable),
        .clear   (bus.rx_valid),
        .expired (to_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // A byte arriving in the cycle the timeout fires takes priority over it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (is_sync) state_d = LEN;
            LEN: begin
                if (bus.rx_valid) begin
                    if (len_cnt_q == 2'(LOADER_LEN_BYTES - 1)) begin
                        if (len_full == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
                            state_d = CHECK;
`else
                            state_d = DONE;
`endif
                        end else if (len_full > 32'(MAX_BYTES)) begin
                            state_d = ERROR;
                        end else begin
                            state_d = DATA;
                        end
                    end
                end else if (to_expired) begin
                    state_d = ERROR;
                end
            end
            DATA: begin
                if (bus.rx_valid) begin
                    if (idx_q == len_q - 32'd1) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = CHECK;
`else
                        state_d = DONE;
`endif
                    end
                end else if (to_expired) begin
                    state_d = ERROR;
                end
            end
            CHECK: begin
`ifdef LOADER_CHECKSUM_EN
                if (bus.rx_valid) state_d = (bus.rx_data == sum_q) ? DONE : ERROR;
                else if (to_expired) state_d = ERROR;
`else
                state_d = ERROR;
`endif
            end
            DONE, ERROR: if (is_sync) state_d = LEN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q     <= '0;
            len_cnt_q <= '0;
            idx_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q     <= '0;
`endif
        end else begin
            wr_en_q <= 1'b0;
            if (bus.rx_valid) begin
                case (state_q)
                    IDLE, DONE, ERROR: begin
                        if (is_sync) begin
                            len_q     <= '0;
                            len_cnt_q <= '0;
`ifdef LOADER_CHECKSUM_EN
                            sum_q     <= '0;
`endif
                        end
                    end
                    LEN: begin
                        len_q     <= len_full;
                        len_cnt_q <= len_cnt_q + 2'd1;
                        idx_q     <= '0;
                    end
                    DATA: begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= BASE_ADDR + idx_q;
                        wr_data_q <= bus.rx_data;
                        idx_q     <= idx_q + 32'd1;
`ifdef LOADER_CHECKSUM_EN
                        sum_q     <= sum_q + bus.rx_data;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.write_enable  = wr_en_q;
    assign bus.write_address = wr_addr_q;
    assign bus.write_data    = wr_data_q;
    assign cpu_reset_n       = (state_q == DONE);
    assign load_done         = (state_q == DONE);
    assign load_error        = (state_q == ERROR);
    assign state_dbg         = state_q;

endmodule
